// File: rtl/adc_sample_capture.sv
// ADC capture front-end: sync differential strobe/data, capture on strobe fall,
// stream num_samp samples. Option: ADC_OFFSET_BINARY_EN (MSB flip on output).
module adc_sample_capture #(
  parameter int SW          = 8,
  parameter int CW          = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_p,
  input  logic          enable_n,
  input  logic [SW-1:0] sample_p,
  input  logic [SW-1:0] sample_n,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] num_samp,
  output logic [SW-1:0] s_data,
  output logic          s_valid,
  input  logic          s_ready,
  output logic          busy,
  output logic          done,
  output logic          overrun,
  output logic          diff_err,
  output logic [CW-1:0] samp_cnt
);

  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] enp_sync_q, enp_sync_d;
  logic [SYNC_STAGES-1:0] enn_sync_q, enn_sync_d;
  logic [SYNC_STAGES-1:0][SW-1:0] smpp_sync_q, smpp_sync_d;
  logic [SYNC_STAGES-1:0][SW-1:0] smpn_sync_q, smpn_sync_d;

  logic          en_prev_q, en_prev_d;
  logic          cap_q, cap_d;
  logic [SW-1:0] cap_p_q, cap_p_d;
  logic [SW-1:0] cap_n_q, cap_n_d;
  logic          cap_en_n_q, cap_en_n_d;
  logic          chk_q, chk_d;
  logic [SW-1:0] chk_data_q, chk_data_d;
  logic [SW-1:0] out_data_q, out_data_d;
  logic          out_vld_q, out_vld_d;
  logic [SW-1:0] skid_data_q, skid_data_d;
  logic          skid_vld_q, skid_vld_d;
  logic [CW-1:0] target_q, target_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, overrun_d;
  logic          diff_err_q, diff_err_d;

  logic          en_s, enn_s, fall, go, accept, push, mismatch;
  logic [SW-1:0] smp_s, smpn_s, conv_data;

  assign en_s   = enp_sync_q[SYNC_STAGES-1];
  assign enn_s  = enn_sync_q[SYNC_STAGES-1];
  assign smp_s  = smpp_sync_q[SYNC_STAGES-1];
  assign smpn_s = smpn_sync_q[SYNC_STAGES-1];
  assign fall   = en_prev_q & ~en_s;

`ifdef ADC_OFFSET_BINARY_EN
  assign conv_data = {~cap_p_q[SW-1], cap_p_q[SW-2:0]};
`else
  assign conv_data = cap_p_q;
`endif

  // At the fall enable_p is low, so a healthy pair has enable_n high
  assign mismatch = ~cap_en_n_q | (|(~(cap_p_q ^ cap_n_q)));

  always_comb begin
    state_d     = state_q;
    enp_sync_d  = {enp_sync_q[SYNC_STAGES-2:0], enable_p};
    enn_sync_d  = {enn_sync_q[SYNC_STAGES-2:0], enable_n};
    smpp_sync_d = {smpp_sync_q[SYNC_STAGES-2:0], sample_p};
    smpn_sync_d = {smpn_sync_q[SYNC_STAGES-2:0], sample_n};
    en_prev_d   = en_s;
    cap_d       = fall & (state_q == RUN);
    cap_p_d     = smp_s;
    cap_n_d     = smpn_s;
    cap_en_n_d  = enn_s;
    chk_d       = cap_q;
    chk_data_d  = conv_data;
    out_data_d  = out_data_q;
    out_vld_d   = out_vld_q;
    skid_data_d = skid_data_q;
    skid_vld_d  = skid_vld_q;
    target_d    = target_q;
    cnt_d       = cnt_q;
    overrun_d   = overrun_q;
    diff_err_d  = diff_err_q | (cap_q & mismatch);

    go     = start & ~abort & ((state_q == IDLE) | (state_q == DONE));
    accept = out_vld_q & s_ready & (state_q == RUN);
    push   = chk_q & (state_q == RUN);

    if (accept) begin
      out_vld_d  = skid_vld_q;
      skid_vld_d = 1'b0;
      if (skid_vld_q) out_data_d = skid_data_q;
    end

    if (push) begin
      if (!out_vld_q || (accept && !skid_vld_q)) begin
        out_vld_d  = 1'b1;
        out_data_d = chk_data_q;
      end else if (!skid_vld_q || accept) begin
        skid_vld_d  = 1'b1;
        skid_data_d = chk_data_q;
      end else begin
        overrun_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (go) begin
          target_d   = num_samp;
          cnt_d      = '0;
          overrun_d  = 1'b0;
          diff_err_d = 1'b0;
          out_vld_d  = 1'b0;
          skid_vld_d = 1'b0;
          cap_d      = 1'b0;
          chk_d      = 1'b0;
          state_d    = (num_samp == '0) ? DONE : ARM;
        end
      end
      ARM: begin
        if (!en_s) state_d = RUN;
      end
      RUN: begin
        if (accept && cnt_q != target_q) begin
          cnt_d = cnt_q + CW'(1);
          // Final transfer: drop anything still buffered
          if (cnt_q + CW'(1) == target_q) begin
            state_d    = DONE;
            out_vld_d  = 1'b0;
            skid_vld_d = 1'b0;
          end
        end
      end
    endcase

    if (abort) begin
      state_d    = IDLE;
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
      cap_d      = 1'b0;
      chk_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      enp_sync_q  <= '0;
      enn_sync_q  <= '0;
      smpp_sync_q <= '0;
      smpn_sync_q <= '0;
      en_prev_q   <= 1'b0;
      cap_q       <= 1'b0;
      cap_p_q     <= '0;
      cap_n_q     <= '0;
      cap_en_n_q  <= 1'b0;
      chk_q       <= 1'b0;
      chk_data_q  <= '0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      skid_data_q <= '0;
      skid_vld_q  <= 1'b0;
      target_q    <= '0;
      cnt_q       <= '0;
      overrun_q   <= 1'b0;
      diff_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      enp_sync_q  <= enp_sync_d;
      enn_sync_q  <= enn_sync_d;
      smpp_sync_q <= smpp_sync_d;
      smpn_sync_q <= smpn_sync_d;
      en_prev_q   <= en_prev_d;
      cap_q       <= cap_d;
      cap_p_q     <= cap_p_d;
      cap_n_q     <= cap_n_d;
      cap_en_n_q  <= cap_en_n_d;
      chk_q       <= chk_d;
      chk_data_q  <= chk_data_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      skid_data_q <= skid_data_d;
      skid_vld_q  <= skid_vld_d;
      target_q    <= target_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      diff_err_q  <= diff_err_d;
    end
  end

  assign s_data   = out_data_q;
  assign s_valid  = out_vld_q;
  assign busy     = (state_q == ARM) | (state_q == RUN);
  assign done     = (state_q == DONE);
  assign overrun  = overrun_q;
  assign diff_err = diff_err_q;
  assign samp_cnt = cnt_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// Bench for adc_sample_capture: table-driven basic run, directed corner
// sequences and randomized runs against a queue-based stream model.
module tb_adc_sample_capture;
  localparam int SW = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable_p, enable_n;
  logic [SW-1:0] sample_p, sample_n;
  logic          start, abort;
  logic [CW-1:0] num_samp;
  logic [SW-1:0] s_data;
  logic          s_valid, s_ready;
  logic          busy, done, overrun, diff_err;
  logic [CW-1:0] samp_cnt;

  adc_sample_capture #(.SW(SW), .CW(CW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .enable_p(enable_p), .enable_n(enable_n),
    .sample_p(sample_p), .sample_n(sample_n),
    .start(start), .abort(abort), .num_samp(num_samp),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .busy(busy), .done(done), .overrun(overrun),
    .diff_err(diff_err), .samp_cnt(samp_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] smp;
    logic [SW-1:0] exp;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;
  bit rnd_mode = 1'b0;
  bit busy_seen, valid_seen;
  logic [SW-1:0] got[$];
  logic [SW-1:0] expq[$];
  vec_t tbl[5];

  function automatic logic [SW-1:0] conv(input logic [SW-1:0] d);
`ifdef ADC_OFFSET_BINARY_EN
    return d + 8'd128;
`else
    return d;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic strobe(input logic [SW-1:0] d, input bit bad);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #3;
      if (c == 0) begin
        sample_p = d;
        sample_n = ~d;
        if (bad) sample_n[3] = d[3];
        enable_p = 1'b1;
        enable_n = 1'b0;
      end
      if (c == 25) begin
        enable_p = 1'b0;
        enable_n = 1'b1;
      end
      if (rnd_mode) s_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic pulse_start(input logic [CW-1:0] n);
    @(posedge clk);
    #1;
    num_samp = n;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_s_data"}, 32'(s_data), 0);
    chk({tag, "_s_valid"}, 32'(s_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
    chk({tag, "_diff_err"}, 32'(diff_err), 0);
    chk({tag, "_samp_cnt"}, samp_cnt, 0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
      if (s_valid) valid_seen = 1'b1;
      if (s_valid && s_ready && !rst) got.push_back(s_data);
    end
  end

  initial begin
    int n, k;
    bit any_bad, bad;
    logic [SW-1:0] d;

`ifdef ADC_OFFSET_BINARY_EN
    tbl[0] = '{8'h80, 8'h00};
    tbl[1] = '{8'h81, 8'h01};
    tbl[2] = '{8'h7F, 8'hFF};
    tbl[3] = '{8'hFF, 8'h7F};
    tbl[4] = '{8'h00, 8'h80};
`else
    tbl[0] = '{8'h80, 8'h80};
    tbl[1] = '{8'h81, 8'h81};
    tbl[2] = '{8'h7F, 8'h7F};
    tbl[3] = '{8'hFF, 8'hFF};
    tbl[4] = '{8'h00, 8'h00};
`endif

    rst = 1'b1;
    enable_p = 1'b0;
    enable_n = 1'b1;
    sample_p = '0;
    sample_n = '1;
    start = 1'b0;
    abort = 1'b0;
    num_samp = '0;
    s_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;

    // Basic run from the table
    got.delete();
    pulse_start(32'd5);
    for (int i = 0; i < 5; i++) strobe(tbl[i].smp, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("basic_xfers", 32'(got.size()), 5);
    for (int i = 0; i < 5 && i < got.size(); i++)
      chk($sformatf("basic_data%0d", i), 32'(got[i]), 32'(tbl[i].exp));
    chk("basic_done", 32'(done), 1);
    chk("basic_busy", 32'(busy), 0);
    chk("basic_cnt", samp_cnt, 5);

    // Backpressure: two held, third dropped
    got.delete();
    s_ready = 1'b0;
    pulse_start(32'd2);
    strobe(8'h10, 1'b0);
    strobe(8'h20, 1'b0);
    strobe(8'h30, 1'b0);
    #1;
    chk("bp_overrun", 32'(overrun), 1);
    chk("bp_valid", 32'(s_valid), 1);
    chk("bp_cnt_held", samp_cnt, 0);
    s_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("bp_xfers", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("bp_data0", 32'(got[0]), 32'(conv(8'h10)));
      chk("bp_data1", 32'(got[1]), 32'(conv(8'h20)));
    end
    chk("bp_cnt", samp_cnt, 2);
    chk("bp_done", 32'(done), 1);

    // Zero length
    pulse_abort();
    chk("abort_idle_done", 32'(done), 0);
    busy_seen = 1'b0;
    valid_seen = 1'b0;
    pulse_start(32'd0);
    chk("zero_done", 32'(done), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("zero_busy_seen", 32'(busy_seen), 0);
    chk("zero_valid_seen", 32'(valid_seen), 0);

    // Start while a strobe is high: that strobe is ignored
    got.delete();
    @(posedge clk);
    #3;
    sample_p = 8'h11;
    sample_n = ~sample_p;
    enable_p = 1'b1;
    enable_n = 1'b0;
    repeat (10) @(posedge clk);
    pulse_start(32'd2);
    repeat (13) @(posedge clk);
    #3;
    enable_p = 1'b0;
    enable_n = 1'b1;
    repeat (24) @(posedge clk);
    strobe(8'h22, 1'b0);
    strobe(8'h33, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_xfers", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("mid_data0", 32'(got[0]), 32'(conv(8'h22)));
      chk("mid_data1", 32'(got[1]), 32'(conv(8'h33)));
    end
    chk("mid_done", 32'(done), 1);

    // Differential fault on bit 3
    got.delete();
    pulse_start(32'd3);
    strobe(8'h3C, 1'b0);
    chk("diff_clean", 32'(diff_err), 0);
    strobe(8'h5A, 1'b1);
    chk("diff_set", 32'(diff_err), 1);
    strobe(8'h99, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("diff_sticky", 32'(diff_err), 1);
    chk("diff_xfers", 32'(got.size()), 3);
    if (got.size() == 3)
      chk("diff_data1", 32'(got[1]), 32'(conv(8'h5A)));
    pulse_start(32'd1);
    chk("diff_cleared", 32'(diff_err), 0);
    pulse_abort();

    // Abort after 2 of 10
    got.delete();
    pulse_start(32'd10);
    strobe(8'h01, 1'b0);
    strobe(8'h02, 1'b0);
    pulse_abort();
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_valid", 32'(s_valid), 0);
    chk("abort_xfers", 32'(got.size()), 2);

    // Latency from first clk edge sampling enable_p low
    pulse_start(32'd1);
    s_ready = 1'b0;
    @(posedge clk);
    #3;
    sample_p = 8'h42;
    sample_n = ~sample_p;
    enable_p = 1'b1;
    enable_n = 1'b0;
    repeat (25) @(posedge clk);
    #3;
    enable_p = 1'b0;
    enable_n = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("lat_early", 32'(s_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_valid", 32'(s_valid), 1);
    chk("lat_data", 32'(s_data), 32'(conv(8'h42)));
    repeat (3) @(posedge clk);
    #1;
    chk("lat_hold", 32'(s_data), 32'(conv(8'h42)));
    s_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("lat_done", 32'(done), 1);
    chk("lat_cnt", samp_cnt, 1);

    // Randomized runs against the stream model
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 8);
      got.delete();
      expq.delete();
      any_bad = 1'b0;
      pulse_start(CW'(n));
      rnd_mode = 1'b1;
      k = 0;
      while (!done && k < n + 2) begin
        d = 8'($urandom_range(0, 255));
        bad = (k < n) && ($urandom_range(0, 7) == 0);
        if (k < n) expq.push_back(conv(d));
        any_bad |= bad;
        strobe(d, bad);
        k++;
      end
      rnd_mode = 1'b0;
      s_ready = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      chk($sformatf("rnd%0d_done", r), 32'(done), 1);
      chk($sformatf("rnd%0d_xfers", r), 32'(got.size()), 32'(n));
      for (int i = 0; i < n && i < got.size(); i++)
        chk($sformatf("rnd%0d_data%0d", r, i), 32'(got[i]), 32'(expq[i]));
      chk($sformatf("rnd%0d_cnt", r), samp_cnt, 32'(n));
      chk($sformatf("rnd%0d_overrun", r), 32'(overrun), 0);
      chk($sformatf("rnd%0d_diff", r), 32'(diff_err), 32'(any_bad));
    end

    // Reset mid-run with flags set
    s_ready = 1'b0;
    pulse_start(32'd10);
    strobe(8'h05, 1'b0);
    strobe(8'h06, 1'b1);
    strobe(8'h07, 1'b0);
    #1;
    chk("pre_rst_overrun", 32'(overrun), 1);
    chk("pre_rst_diff", 32'(diff_err), 1);
    chk("pre_rst_busy", 32'(busy), 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    rst = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
